mips_sequencer: RTL and testbench
=================================

# mips_sequencer

Top-level control FSM for the multi-cycle MIPS core: generates the `state` code consumed by `mips_decoder` (FETCH/EXEC1/EXEC2/HALT) and sequences each instruction through fetch and execute. It advances on Avalon `waitrequest`, the decoder's `Extra` flag and the multiply/divide unit's busy flag. It also owns the CPU `active` output, the instruction-register load strobe and the fetch-read gate. It sits between the Avalon memory port, `mips_decoder` and the instruction register in the CPU top level.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `waitrequest`  in  1  Avalon memory busy; stalls the current memory phase.
- `halt_pc`  in  1  decoder `Halt` (PC == 0x0).
- `extra`  in  1  decoder `Extra`; the instruction needs EXEC2.
- `md_busy`  in  1  multiply/divide unit still computing.
- `state`  out  2  FETCH=00, EXEC1=01, EXEC2=10, HALT=11; registered.
- `active`  out  1  CPU running; registered.
- `fetch_read`  out  1  gated instruction read request.
- `ir_en`  out  1  instruction-register load strobe.
- `stall`  out  1  current cycle is a stall cycle.
- `instr_retired`  out  1  one-cycle pulse on instruction completion.

## Operation
- **Reset values:** `state`=FETCH, `active`=0, all other outputs 0.
- **First post-reset edge:** with `reset` low, `active`→1. No fetch is issued in this idle cycle.
- **FETCH**
  - `fetch_read` = `active` & !`halt_pc`.
  - `halt_pc`=1 → HALT.
  - Else if `waitrequest`: hold, `stall`=1.
  - Else `ir_en`=1 → EXEC1.
- **EXEC1**
  - `waitrequest` or `md_busy`: hold, `stall`=1.
  - Else `extra`=1 → EXEC2.
  - Else → FETCH with `instr_retired`=1.
- **EXEC2:** unconditional → FETCH with `instr_retired`=1. No memory access, so no stall.
- **HALT:** sticky until `reset`. `active`=0 from the cycle HALT is entered. Every strobe is 0.
- **Combinational outputs:** `ir_en`, `fetch_read`, `stall` and `instr_retired` decode from the registered state plus the current inputs. `stall` and `ir_en`/`instr_retired` are mutually exclusive in the same cycle.
- **`halt_pc` priority:** `halt_pc` outranks `waitrequest` in FETCH. It is ignored in EXEC1/EXEC2, where the PC is being updated.
- **Unknown `state` encoding:** never reached; the default branch → HALT.

## Timing
- Two-cycle instruction, no stalls: FETCH, EXEC1 → 2 clocks.
- Load: FETCH, EXEC1, EXEC2 → 3 clocks.
- Each `waitrequest`/`md_busy` cycle adds exactly one clock to the phase it occurs in.
- Halt latency: `halt_pc` sampled in FETCH → `state`=HALT and `active`=0 one edge later.
- Reset mid-operation: `state`=FETCH and `active`=0 immediately, with no clock edge needed. The in-flight instruction is dropped, not retired.
- Simultaneous `md_busy` and `waitrequest`: one stall cycle per clock, not cumulative.

## Configuration
- **`MIPS_SEQ_PERF_CNT_EN` defined:** adds three outputs, each 32-bit unsigned, wrapping 0xFFFFFFFF→0, reset 0, frozen in HALT.
  - `cycle_count`: counts every clock with `active`=1.
  - `instr_count`: increments on `instr_retired`.
  - `stall_count`: increments on `stall`.
- **Not defined:** ports and counters are absent; FSM behaviour is identical.

## Structure
- **`mips_pkg`** holds the shared definitions:
  - `typedef enum logic [1:0] state_t {FETCH, EXEC1, EXEC2, HALT}`, shared with `mips_decoder`.
  - Constant `RESET_VECTOR` = 32'hBFC00000, used by the PC block.
- **`mips_perf_counter`:** 32-bit enable/wrap counter, instantiated three times under the macro.

## Test plan
- **Basic ALU instruction:** reset, release, `waitrequest`=0, `extra`=0 → idle cycle with `active` 0→1, then FETCH (`ir_en`=1), EXEC1 (`instr_retired`=1), FETCH.
- **Load with memory stall:** FETCH clean, EXEC1 with `waitrequest` high 2 cycles, `extra`=1 → EXEC1 held 3 clocks with `stall`=1 for 2, then EXEC2, then FETCH with `instr_retired`=1.
- **Halt:** `halt_pc`=1 and `waitrequest`=1 in FETCH → `fetch_read`=0, next edge `state`=11, `active`=0; remains so for 100 cycles despite input toggling.
- **Multiply/divide busy:** `md_busy` high 5 cycles in EXEC1 → EXEC1 lasts 6 clocks; exit to FETCH on the 6th.
- **Async reset mid-instruction:** assert `reset` mid-EXEC2 between clock edges → `state`=00 and `active`=0 before the next edge; `instr_retired` never pulses.
- **Performance counters:** with `MIPS_SEQ_PERF_CNT_EN`, run 4 ALU instructions plus 1 load with 2 stall cycles, then halt → `instr_count`=5, `stall_count`=2, `cycle_count`=13 at halt, unchanged afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: sequencer state codes and the PC reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_perf_counter.sv
// Free-running event counter with enable; wraps from all-ones back to zero.
module mips_perf_counter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/mips_sequencer.sv
// Top-level control FSM of the multi-cycle MIPS core (FETCH/EXEC1/EXEC2/HALT).
// Optional performance counters are built when MIPS_SEQ_PERF_CNT_EN is defined.
module mips_sequencer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        halt_pc,
  input  logic        extra,
  input  logic        md_busy,
  output logic [1:0]  state,
  output logic        active,
  output logic        fetch_read,
  output logic        ir_en,
  output logic        stall,
  output logic        instr_retired
`ifdef MIPS_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  state_t state_q;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      active  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          // The first cycle out of reset only raises active; no fetch is issued.
          if (!active) begin
            active <= 1'b1;
          end else if (halt_pc) begin
            state_q <= HALT;
            active  <= 1'b0;
          end else if (!waitrequest) begin
            state_q <= EXEC1;
          end
        end
        EXEC1: begin
          if (!(waitrequest || md_busy)) begin
            state_q <= extra ? EXEC2 : FETCH;
          end
        end
        EXEC2: state_q <= FETCH;
        HALT:  active <= 1'b0;
        default: begin
          state_q <= HALT;
          active  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fetch_read    = 1'b0;
    ir_en         = 1'b0;
    stall         = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_read = active && !halt_pc;
        if (active && !halt_pc) begin
          if (waitrequest) begin
            stall = 1'b1;
          end else begin
            ir_en = 1'b1;
          end
        end
      end
      EXEC1: begin
        if (waitrequest || md_busy) begin
          stall = 1'b1;
        end else if (!extra) begin
          instr_retired = 1'b1;
        end
      end
      EXEC2:   instr_retired = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_SEQ_PERF_CNT_EN
  logic cycle_en;

  // The FETCH cycle that decides to halt is billed to HALT, so it is not counted.
  assign cycle_en = active && !(state_q == FETCH && halt_pc);

  mips_perf_counter #(.DATA_W(32)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cycle_en),
    .count (cycle_count)
  );

  mips_perf_counter #(.DATA_W(32)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (instr_retired),
    .count (instr_count)
  );

  mips_perf_counter #(.DATA_W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall),
    .count (stall_count)
  );
`endif

endmodule

// File: tb/tb_mips_sequencer.sv
// Bench for mips_sequencer: vector table, hand-written corner sequences and randomized run against a phase model.
module tb_mips_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        waitrequest = 1'b0;
  logic        halt_pc = 1'b0;
  logic        extra = 1'b0;
  logic        md_busy = 1'b0;
  logic [1:0]  state;
  logic        active, fetch_read, ir_en, stall, instr_retired;
`ifdef MIPS_SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count, stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  mips_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .waitrequest   (waitrequest),
    .halt_pc       (halt_pc),
    .extra         (extra),
    .md_busy       (md_busy),
    .state         (state),
    .active        (active),
    .fetch_read    (fetch_read),
    .ir_en         (ir_en),
    .stall         (stall),
    .instr_retired (instr_retired)
`ifdef MIPS_SEQ_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .instr_count   (instr_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: instruction phase 0=fetch, 1=exec1, 2=exec2, plus running/halted flags.
  bit          m_active, m_halted;
  int          m_phase;
  int unsigned m_cyc, m_ins, m_stl;

  function automatic logic [6:0] model_out(logic w, logic h, logic e, logic m);
    logic fr, ir, sl, rt;
    fr = 1'b0; ir = 1'b0; sl = 1'b0; rt = 1'b0;
    if (m_halted) return 7'b1100000;
    case (m_phase)
      0: if (m_active && !h) begin
           fr = 1'b1;
           if (w) sl = 1'b1; else ir = 1'b1;
         end
      1: if (w || m) sl = 1'b1; else if (!e) rt = 1'b1;
      default: rt = 1'b1;
    endcase
    return {2'(m_phase), m_active, fr, ir, sl, rt};
  endfunction

  function automatic void model_step(logic w, logic h, logic e, logic m);
    logic [6:0] o;
    o = model_out(w, h, e, m);
    if (m_halted) return;
    if (m_active && !(m_phase == 0 && h)) m_cyc++;
    if (o[0]) m_ins++;
    if (o[1]) m_stl++;
    if (!m_active) begin
      m_active = 1'b1;
      return;
    end
    case (m_phase)
      0: if (h) begin m_halted = 1'b1; m_active = 1'b0; end
         else if (!w) m_phase = 1;
      1: if (!(w || m)) m_phase = e ? 2 : 0;
      default: m_phase = 0;
    endcase
  endfunction

  function automatic logic [6:0] dut_out();
    return {state, active, fetch_read, ir_en, stall, instr_retired};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic w, input logic h, input logic e, input logic m,
                     output logic [6:0] got, output logic [6:0] exp);
    waitrequest = w; halt_pc = h; extra = e; md_busy = m;
    #4;
    got = dut_out();
    exp = model_out(w, h, e, m);
`ifdef MIPS_SEQ_PERF_CNT_EN
    check("cycle_count", cycle_count, m_cyc);
    check("instr_count", instr_count, m_ins);
    check("stall_count", stall_count, m_stl);
`endif
    model_step(w, h, e, m);
    @(posedge clk);
    #1;
  endtask

  task automatic mcyc(input string name, input logic w, input logic h, input logic e, input logic m);
    logic [6:0] g, x;
    cyc(w, h, e, m, g, x);
    check(name, {25'd0, g}, {25'd0, x});
  endtask

  // Asserts reset between clock edges, checks the immediate effect, releases at posedge+1.
  task automatic do_reset();
    waitrequest = 1'b0; halt_pc = 1'b0; extra = 1'b0; md_busy = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_state", {25'd0, dut_out()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_active = 1'b0; m_halted = 1'b0; m_phase = 0;
    m_cyc = 0; m_ins = 0; m_stl = 0;
  endtask

  typedef struct packed {
    logic       w, h, e, m;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [6:0] g, x;
    int n_ex1, n_stl, n_ret;

    // {waitrequest, halt_pc, extra, md_busy, {state, active, fetch_read, ir_en, stall, retired}}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};  // idle cycle after reset
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0011100};  // FETCH
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0110001};  // EXEC1 retire
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0011010};  // FETCH stalled
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0011100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0110010};  // both busy: one stall
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0110010};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0110000};  // extra -> EXEC2
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b1010001};  // EXEC2 ignores halt/wait
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0010000};  // halt outranks waitrequest
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b1100000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000};

    #1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].w, tbl[i].h, tbl[i].e, tbl[i].m, g, x);
      check($sformatf("table[%0d]", i), {25'd0, g}, {25'd0, tbl[i].exp});
    end

    // HALT is sticky regardless of inputs
    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), g, x);
      check("halt_sticky", {25'd0, g}, 32'h60);
    end

    // md_busy for 5 cycles holds EXEC1 for 6 clocks
    do_reset();
    mcyc("mdb_idle", 0, 0, 0, 0);
    mcyc("mdb_fetch", 0, 0, 0, 0);
    n_ex1 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, (i < 5), g, x);
      check("mdb_exec1", {25'd0, g}, {25'd0, x});
      if (g[6:5] == 2'b01) n_ex1++;
    end
    check("mdb_exec1_len", n_ex1, 6);
    mcyc("mdb_back_fetch", 0, 0, 0, 0);

    // Load with two waitrequest cycles in EXEC1
    do_reset();
    mcyc("ld_idle", 0, 0, 0, 0);
    mcyc("ld_fetch", 0, 0, 0, 0);
    n_ex1 = 0; n_stl = 0; n_ret = 0;
    for (int i = 0; i < 4; i++) begin
      cyc((i < 2), 1'b0, 1'b1, 1'b0, g, x);
      check("ld_seq", {25'd0, g}, {25'd0, x});
      if (g[6:5] == 2'b01) n_ex1++;
      n_stl += int'(g[1]);
      n_ret += int'(g[0]);
    end
    check("ld_exec1_len", n_ex1, 3);
    check("ld_stalls", n_stl, 2);
    check("ld_retired", n_ret, 1);
    mcyc("ld_back_fetch", 0, 0, 0, 0);

    // Asynchronous reset in the middle of EXEC2
    mcyc("ar_exec1", 0, 0, 1, 0);
    check("ar_in_exec2", {30'd0, state}, 32'd2);
    do_reset();

`ifdef MIPS_SEQ_PERF_CNT_EN
    do_reset();
    mcyc("pc_idle", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      mcyc("pc_alu_f", 0, 0, 0, 0);
      mcyc("pc_alu_e", 0, 0, 0, 0);
    end
    mcyc("pc_ld_f", 0, 0, 0, 0);
    mcyc("pc_ld_w1", 1, 0, 1, 0);
    mcyc("pc_ld_w2", 1, 0, 1, 0);
    mcyc("pc_ld_e1", 0, 0, 1, 0);
    mcyc("pc_ld_e2", 0, 0, 0, 0);
    mcyc("pc_halt", 0, 1, 0, 0);
    #4;
    check("pc_cycles", cycle_count, 32'd13);
    check("pc_instrs", instr_count, 32'd5);
    check("pc_stalls", stall_count, 32'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) mcyc("pc_halted", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #4;
    check("pc_cycles_frozen", cycle_count, 32'd13);
    check("pc_instrs_frozen", instr_count, 32'd5);
    check("pc_stalls_frozen", stall_count, 32'd2);
    @(posedge clk);
    #1;
`endif

    // Randomized run against the model, re-resetting after halts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && ($urandom_range(7) == 0)) do_reset();
      mcyc("random", ($urandom_range(3) == 0), ($urandom_range(39) == 0),
           1'($urandom), ($urandom_range(4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
